seq_detect_param: RTL

Parametrised serial pattern detector, the next generation of the fixed 4-bit "1001" checker. It samples a qualified serial bit stream against a runtime-loadable, maskable pattern of PAT_W bits, with selectable overlapping or non-overlapping matching. Each match produces a one-cycle hit pulse and a retriggerable stretched flag, and increments a saturating hit counter. It sits directly behind a serial receiver as a framing/marker detector.

---
 rtl/seq_det_pkg.sv | 28 ++
 rtl/seq_detect_param_pulse_stretch.sv | 46 ++++
 rtl/seq_detect_param.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// default pattern, fill-state encoding and the masked pattern compare.
package seq_det_pkg;

    // Widest pattern the detector supports; compares are done at this width.
    localparam int MAX_PAT_W = 32;

    // Pattern loaded at reset; the top zero-extends or truncates it to PAT_W.
    localparam logic [MAX_PAT_W-1:0] DEF_RST_PAT = 32'b1001;

    // FILLING: fewer than PAT_W fresh bits seen, no match possible.
    // ARMED:   a full window of fresh bits is present, every valid bit is compared.
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } fill_state_e;

    // True when every bit selected by mask agrees between data and pat.
    // Callers zero-extend narrower operands; unused upper bits are masked off.
    function automatic logic masked_eq(
        input logic [MAX_PAT_W-1:0] data,
        input logic [MAX_PAT_W-1:0] pat,
        input logic [MAX_PAT_W-1:0] mask
    );
        return ((data ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/seq_detect_param_pulse_stretch.sv
// Retriggerable pulse stretcher: a trigger loads HOLD into a down-counter and
// the output is high while the counter is non-zero.
module pulse_stretch #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst_,
    input  logic trig,
    output logic out
);

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    // Reload on trigger, otherwise count down toward zero every clock.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d = cnt_q;
        if (trig) begin
            cnt_d = HOLD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        out_d = (cnt_d != '0);
    end

    // Counter and registered output flag, synchronously cleared.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst_) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector. Shifts qualified serial bits into a
// window, compares against a loadable masked pattern, and reports each match
// as a one-cycle pulse, a stretched flag and a saturating hit count.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               HOLD    = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             ovlp,
    input  logic             cnt_clr,
    output logic             hit,
    output logic             find_out,
    output logic [CNT_W-1:0] hit_cnt
);

    // The fill counter only runs while FILLING, so it never needs to hold PAT_W.
    localparam int               FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    fill_state_e       state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  sr_q, sr_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hit_q;

    logic [PAT_W-1:0]  shift_val;
    logic              window_full;
    logic              match;

    // Shift register, fill tracking, config load and match decision.
    always_comb begin
        sr_d        = sr_q;
        fill_d      = fill_q;
        state_d     = state_q;
        pat_d       = pat_q;
        mask_d      = mask_q;
        match       = 1'b0;
        shift_val   = {sr_q[PAT_W-2:0], din};
        // The incoming bit completes the window when already armed or when
        // it is the last bit needed to fill it.
        window_full = (state_q == ARMED) || (fill_q == FILL_LAST);

        if (cfg_load) begin
            // Loading wins over data: the bit is dropped and the window refills.
            pat_d   = cfg_pat;
            mask_d  = cfg_mask;
            fill_d  = '0;
            state_d = FILLING;
        end else if (din_valid) begin
            sr_d  = shift_val;
            match = window_full &&
                    masked_eq(MAX_PAT_W'(shift_val), MAX_PAT_W'(pat_q), MAX_PAT_W'(mask_q));
            if (match && !ovlp) begin
                // Non-overlapping: the next match needs a full set of fresh bits.
                fill_d  = '0;
                state_d = FILLING;
            end else if (window_full) begin
                fill_d  = '0;
                state_d = ARMED;
            end else begin
                fill_d  = fill_q + FILL_W'(1);
            end
        end
    end

    // Saturating hit counter; a clear coincident with a match leaves 1.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // All detector state registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= FILLING;
            fill_q  <= '0;
            sr_q    <= '0;
            pat_q   <= RST_PAT;
            mask_q  <= '1;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            sr_q    <= sr_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            hit_q   <= match;
        end
    end

    pulse_stretch #(
        .HOLD (HOLD)
    ) u_stretch (
        .clk  (clk),
        .rst_ (rst_),
        .trig (match),
        .out  (find_out)
    );

    assign hit     = hit_q;
    assign hit_cnt = cnt_q;

endmodule
